// File: rtl/vec_seq_ctrl_if.sv
// Vector stream interface for vec_seq_ctrl: stimulus, expected response and last flag
// handed over with a valid/ready handshake.
interface vec_seq_ctrl_if #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1
);
    logic             vec_valid;
    logic             vec_ready;
    logic [N_IN-1:0]  vec_in;
    logic [N_OUT-1:0] vec_exp;
    logic             vec_last;

    modport master (
        output vec_valid, vec_in, vec_exp, vec_last,
        input  vec_ready
    );

    modport slave (
        input  vec_valid, vec_in, vec_exp, vec_last,
        output vec_ready
    );
endinterface

// File: rtl/vec_seq_ctrl.sv
// Test-vector sequencer: applies vectors to a combinational netlist, waits SETTLE cycles,
// compares the response and counts vectors/mismatches. Optional: VSEQ_STOP_ON_MISMATCH_EN.
module vec_seq_ctrl #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    vec_seq_ctrl_if.slave     vec_if,
    output logic [N_IN-1:0]   dut_in_o,
    input  logic [N_OUT-1:0]  dut_out_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [CNT_W-1:0]  vec_cnt_o,
`ifdef VSEQ_STOP_ON_MISMATCH_EN
    output logic [CNT_W-1:0]  first_fail_idx_o,
`endif
    output logic [CNT_W-1:0]  err_cnt_o
);

    localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
    localparam int SCNT_W     = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE_ST,
        CHECK,
        FIN
    } state_t;

    state_t             state_q;
    logic [SCNT_W-1:0]  settle_cnt_q;
    logic [N_OUT-1:0]   exp_q;
    logic               last_q;
    logic [N_IN-1:0]    dut_in_q;
    logic               vec_ready_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [CNT_W-1:0]   vec_cnt_q;
    logic [CNT_W-1:0]   err_cnt_q;
    logic [CNT_W-1:0]   vec_cnt_d;
    logic [CNT_W-1:0]   err_cnt_d;
    logic               mismatch;
`ifdef VSEQ_STOP_ON_MISMATCH_EN
    logic [CNT_W-1:0]   first_fail_idx_q;
`endif

    assign mismatch  = (dut_out_i != exp_q);
    assign vec_cnt_d = (&vec_cnt_q) ? vec_cnt_q : vec_cnt_q + 1'b1;
    assign err_cnt_d = (mismatch && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            settle_cnt_q     <= '0;
            exp_q            <= '0;
            last_q           <= 1'b0;
            dut_in_q         <= '0;
            vec_ready_q      <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            vec_cnt_q        <= '0;
            err_cnt_q        <= '0;
`ifdef VSEQ_STOP_ON_MISMATCH_EN
            first_fail_idx_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        vec_cnt_q        <= '0;
                        err_cnt_q        <= '0;
                        done_q           <= 1'b0;
                        pass_q           <= 1'b0;
                        busy_q           <= 1'b1;
                        vec_ready_q      <= 1'b1;
`ifdef VSEQ_STOP_ON_MISMATCH_EN
                        first_fail_idx_q <= '0;
`endif
                        state_q          <= LOAD;
                    end
                end
                LOAD: begin
                    if (vec_if.vec_valid && vec_ready_q) begin
                        dut_in_q     <= vec_if.vec_in;
                        exp_q        <= vec_if.vec_exp;
                        last_q       <= vec_if.vec_last;
                        settle_cnt_q <= SCNT_W'(SETTLE_EFF - 1);
                        vec_ready_q  <= 1'b0;
                        state_q      <= SETTLE_ST;
                    end
                end
                SETTLE_ST: begin
                    if (settle_cnt_q == '0) begin
                        state_q <= CHECK;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - 1'b1;
                    end
                end
                CHECK: begin
                    vec_cnt_q <= vec_cnt_d;
                    err_cnt_q <= err_cnt_d;
`ifdef VSEQ_STOP_ON_MISMATCH_EN
                    // Only the first mismatch reaches here: the run ends immediately after it.
                    if (mismatch) begin
                        first_fail_idx_q <= vec_cnt_q;
                        state_q          <= FIN;
                    end else if (last_q) begin
                        state_q <= FIN;
                    end else begin
                        vec_ready_q <= 1'b1;
                        state_q     <= LOAD;
                    end
`else
                    if (last_q) begin
                        state_q <= FIN;
                    end else begin
                        vec_ready_q <= 1'b1;
                        state_q     <= LOAD;
                    end
`endif
                end
                FIN: begin
                    done_q  <= 1'b1;
                    pass_q  <= (err_cnt_q == '0);
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign vec_if.vec_ready = vec_ready_q;
    assign dut_in_o         = dut_in_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign vec_cnt_o        = vec_cnt_q;
    assign err_cnt_o        = err_cnt_q;
`ifdef VSEQ_STOP_ON_MISMATCH_EN
    assign first_fail_idx_o = first_fail_idx_q;
`endif

endmodule

// File: tb/tb_vec_seq_ctrl.sv
// Scoreboard bench for vec_seq_ctrl driving a x=~a&b netlist model; a second instance
// with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_vec_seq_ctrl;

    localparam int N_IN  = 3;
    localparam int N_OUT = 1;

    typedef struct {
        int vecCnt;
        int errCnt;
        int ffi;
    } result_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             startI = 1'b0;
    logic [N_IN-1:0]  dutIn, satDutIn;
    logic [N_OUT-1:0] dutOut, satDutOut;
    logic             busyO, doneO, passO;
    logic [7:0]       vecCntO, errCntO;
    logic             satBusyO, satDoneO, satPassO;
    logic [1:0]       satVecCntO, satErrCntO;
`ifdef VSEQ_STOP_ON_MISMATCH_EN
    logic [7:0]       ffiO;
    logic [1:0]       satFfiO;
`endif

    int checkCount = 0;
    int passCount  = 0;
    int cycle      = 0;
    logic doneD    = 1'b0;

    logic [N_IN-1:0]  dinQ[$];
    result_t          resQ[$];
    logic [N_IN-1:0]  stimVec[8];
    logic [N_OUT-1:0] stimExp[8];

    vec_seq_ctrl_if #(.N_IN(N_IN), .N_OUT(N_OUT)) vecIf ();
    vec_seq_ctrl_if #(.N_IN(N_IN), .N_OUT(N_OUT)) satIf ();

    assign satIf.vec_valid = vecIf.vec_valid;
    assign satIf.vec_in    = vecIf.vec_in;
    assign satIf.vec_exp   = vecIf.vec_exp;
    assign satIf.vec_last  = vecIf.vec_last;

    // Gate-level netlist under test: x = ~a & b
    assign dutOut    = ~dutIn[0] & dutIn[1];
    assign satDutOut = ~satDutIn[0] & satDutIn[1];

    vec_seq_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(startI), .vec_if(vecIf.slave),
        .dut_in_o(dutIn), .dut_out_i(dutOut), .busy_o(busyO), .done_o(doneO),
        .pass_o(passO), .vec_cnt_o(vecCntO),
`ifdef VSEQ_STOP_ON_MISMATCH_EN
        .first_fail_idx_o(ffiO),
`endif
        .err_cnt_o(errCntO)
    );

    vec_seq_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(4), .CNT_W(2)) satDut (
        .clk(clk), .rst_n(rst_n), .start_i(startI), .vec_if(satIf.slave),
        .dut_in_o(satDutIn), .dut_out_i(satDutOut), .busy_o(satBusyO), .done_o(satDoneO),
        .pass_o(satPassO), .vec_cnt_o(satVecCntO),
`ifdef VSEQ_STOP_ON_MISMATCH_EN
        .first_fail_idx_o(satFfiO),
`endif
        .err_cnt_o(satErrCntO)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    function automatic int satVal(input int v, input int maxV);
        return (v > maxV) ? maxV : v;
    endfunction

    // Compare final results whenever a run reports done
    always @(negedge clk) begin
        if (rst_n && doneO && !doneD) begin
            if (resQ.size() == 0) begin
                checkOutput("unexpectedDone", 1, 0);
            end else begin
                result_t r;
                r = resQ.pop_front();
                checkOutput("vecCnt", 32'(vecCntO), 32'(satVal(r.vecCnt, 255)));
                checkOutput("errCnt", 32'(errCntO), 32'(satVal(r.errCnt, 255)));
                checkOutput("pass", 32'(passO), 32'(r.errCnt == 0));
                checkOutput("busyAtDone", 32'(busyO), 0);
                checkOutput("satVecCnt", 32'(satVecCntO), 32'(satVal(r.vecCnt, 3)));
                checkOutput("satErrCnt", 32'(satErrCntO), 32'(satVal(r.errCnt, 3)));
                checkOutput("satPass", 32'(satPassO), 32'(r.errCnt == 0));
                checkOutput("satDone", 32'(satDoneO), 1);
`ifdef VSEQ_STOP_ON_MISMATCH_EN
                checkOutput("firstFailIdx", 32'(ffiO), 32'(r.ffi));
`endif
            end
        end
        doneD = doneO;
    end

    task automatic applyStimulus(input int n, input int stallAfter, input int abortAfter, input bit checkSpacing);
        result_t r;
        int nAcc = 0;
        int prevHs = 0;
        bit mis;
        r.errCnt = 0;
        r.ffi = 0;
        for (int i = 0; i < n; i++) begin
            nAcc++;
            mis = (stimExp[i][0] != (~stimVec[i][0] & stimVec[i][1]));
            if (mis) r.errCnt++;
`ifdef VSEQ_STOP_ON_MISMATCH_EN
            if (mis) begin
                r.ffi = i;
                break;
            end
`endif
        end
        r.vecCnt = nAcc;
        if (abortAfter < 0) resQ.push_back(r);

        @(negedge clk) startI = 1'b1;
        @(negedge clk) startI = 1'b0;
        checkOutput("busyAfterStart", 32'(busyO), 1);

        for (int i = 0; i < nAcc; i++) begin
            bit gotReady = 1'b0;
            vecIf.vec_valid = 1'b1;
            vecIf.vec_in    = stimVec[i];
            vecIf.vec_exp   = stimExp[i];
            vecIf.vec_last  = (i == n - 1);
            for (int w = 0; w < 50; w++) begin
                if (vecIf.vec_ready) begin
                    gotReady = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!gotReady) begin
                checkOutput("readyTimeout", 0, 1);
                vecIf.vec_valid = 1'b0;
                return;
            end
            @(posedge clk);
            dinQ.push_back(stimVec[i]);
            if (checkSpacing && i > 0) checkOutput("hsSpacing", 32'(cycle - prevHs), 6);
            prevHs = cycle;
            #1;
            checkOutput("dutIn", 32'(dutIn), 32'(dinQ.pop_front()));
            if (i == nAcc - 1) vecIf.vec_valid = 1'b0;
            if (i == stallAfter) begin
                vecIf.vec_valid = 1'b0;
                repeat (10) @(negedge clk);
                checkOutput("stallReady", 32'(vecIf.vec_ready), 1);
                checkOutput("stallDutIn", 32'(dutIn), 32'(stimVec[i]));
            end
            if (i == abortAfter) begin
                vecIf.vec_valid = 1'b0;
                @(posedge clk);
                @(posedge clk);
                #1 rst_n = 1'b0;
                #1;
                checkOutput("abortBusy", 32'(busyO), 0);
                checkOutput("abortVecCnt", 32'(vecCntO), 0);
                checkOutput("abortDutIn", 32'(dutIn), 0);
                checkOutput("abortReady", 32'(vecIf.vec_ready), 0);
                @(negedge clk) rst_n = 1'b1;
                repeat (12) @(negedge clk);
                checkOutput("abortNoDone", 32'(doneO), 0);
                return;
            end
            @(negedge clk);
        end

        for (int w = 0; w < 100 && resQ.size() != 0; w++) @(negedge clk);
        if (resQ.size() != 0) begin
            checkOutput("doneTimeout", 32'(resQ.size()), 0);
            resQ.delete();
        end
        @(negedge clk);
        checkOutput("doneHeld", 32'(doneO), 1);
    endtask

    task automatic loadClean();
        stimVec[0] = 3'b000; stimExp[0] = 1'b0;
        stimVec[1] = 3'b010; stimExp[1] = 1'b1;
        stimVec[2] = 3'b001; stimExp[2] = 1'b0;
        stimVec[3] = 3'b011; stimExp[3] = 1'b0;
    endtask

    initial begin
        vecIf.vec_valid = 1'b0;
        vecIf.vec_in    = '0;
        vecIf.vec_exp   = '0;
        vecIf.vec_last  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rstDutIn", 32'(dutIn), 0);
        checkOutput("rstReady", 32'(vecIf.vec_ready), 0);
        checkOutput("rstBusy", 32'(busyO), 0);
        checkOutput("rstDone", 32'(doneO), 0);
        checkOutput("rstPass", 32'(passO), 0);
        checkOutput("rstVecCnt", 32'(vecCntO), 0);
        checkOutput("rstErrCnt", 32'(errCntO), 0);

        $display("[TB] clean run");
        loadClean();
        applyStimulus(4, -1, -1, 1'b1);

        $display("[TB] mismatch run");
        loadClean();
        stimExp[1] = 1'b0;
        applyStimulus(4, -1, -1, 1'b0);

        $display("[TB] stall run");
        loadClean();
        applyStimulus(4, 1, -1, 1'b0);

        $display("[TB] saturation run");
        for (int i = 0; i < 5; i++) begin
            stimVec[i] = 3'b010;
            stimExp[i] = 1'b0;
        end
        applyStimulus(5, -1, -1, 1'b0);

        $display("[TB] abort run");
        loadClean();
        applyStimulus(4, -1, 1, 1'b0);

        $display("[TB] clean run after abort");
        loadClean();
        applyStimulus(4, -1, -1, 1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/vec_seq_ctrl.md
Name: vec_seq_ctrl

Overview:
Test-vector sequencer for the gate-level combinational netlists simulated in this codebase, such as the not/and samples with #2 delays. It accepts vectors through a valid/ready stream and drives them onto the netlist inputs. It waits a programmable settle time covering gate propagation delay, then samples the netlist outputs and compares them against expected values. It counts applied vectors and mismatches and reports pass/fail at the end of a run.

Parameters:
N_IN, 3, netlist input width (e.g. a,b,c)
N_OUT, 1, netlist output width (e.g. x)
SETTLE, 4, clock cycles between driving dut_in and sampling dut_out; values below 1 are treated as 1
CNT_W, 8, width of the vector and error counters

Ports:
clk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run when not busy
vec_valid  in  1  vector stream valid
vec_ready  out  1  vector stream ready
vec_in  in  N_IN  stimulus vector
vec_exp  in  N_OUT  expected netlist response
vec_last  in  1  marks the final vector of the run
dut_in  out  N_IN  drives netlist inputs
dut_out  in  N_OUT  netlist outputs
busy  out  1  run in progress
done  out  1  run complete; held until the next start
pass  out  1  valid when done; 1 iff err_cnt==0
vec_cnt  out  CNT_W  vectors checked this run, saturating
err_cnt  out  CNT_W  mismatches this run, saturating

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - dut_in=0, vec_ready=0, busy=0, done=0, pass=0, vec_cnt=0, err_cnt=0.
  - Internal settle counter, expected-value register and last flag are cleared.
- FSM states: IDLE, LOAD, SETTLE, CHECK, FIN.
- IDLE:
  - On start, clear vec_cnt, err_cnt, done and pass; set busy=1; go to LOAD.
  - start in any other state is ignored.
- LOAD:
  - vec_ready=1; this is the only state in which vec_ready is high.
  - On vec_valid&&vec_ready (cycle t): register vec_in into dut_in (visible at t+1), capture vec_exp and vec_last, load settle counter with SETTLE-1, go to SETTLE.
  - vec_valid low: stay in LOAD; dut_in holds its previous vector.
- SETTLE:
  - Decrement the counter each cycle; at 0 go to CHECK.
  - dut_in stays stable throughout.
- CHECK (one cycle):
  - Sample dut_out and compare it bitwise with the captured expected value.
  - vec_cnt+=1 (saturating at all-ones).
  - On any bit mismatch, err_cnt+=1 (saturating).
  - If the captured last flag is set, go to FIN; otherwise go to LOAD.
- Timing: dut_out is sampled at cycle t+SETTLE+1 after the handshake, giving SETTLE full cycles of propagation. Minimum vector period is SETTLE+2 cycles.
- FIN (one cycle):
  - Set done=1; pass=(err_cnt==0), taking into account the final CHECK update.
  - busy=0; return to IDLE.
  - done and pass hold until the next start or reset.
- dut_in is not cleared at the end of a run; it holds the last vector.
- An empty run is not possible: each run consumes at least one vector, and the run ends only on vec_last.
- Counter saturation: vec_cnt and err_cnt stop at 2^CNT_W-1 and do not wrap. pass uses the saturated err_cnt, so a saturated error count still means pass=0.
- Reset mid-run aborts immediately. No done is produced and no partial results are retained.
- dut_out is assumed synchronous to clk, since it is driven combinationally from dut_in. No synchronizer is used.

Optional Feature:
Macro VSEQ_STOP_ON_MISMATCH_EN.
- Defined:
  - Output first_fail_idx [CNT_W-1:0] is added; reset value 0.
  - On the first mismatch of a run, CHECK records the pre-increment vec_cnt into first_fail_idx and goes directly to FIN. Remaining vectors are not consumed.
  - first_fail_idx holds until the next start, when it clears to 0.
- Not defined: the port is absent and every run continues through vec_last regardless of mismatches.

Test Plan:
All scenarios use N_IN=3, N_OUT=1, SETTLE=4, with the netlist computing x=~a&b (dut_in[0]=a, dut_in[1]=b).
- Reset: hold rst_n=0, release -> all outputs 0, vec_ready=0, FSM in IDLE.
- Clean run: start; vectors {a,b}=00,01,10,11 with expected 0,1,0,0, last on the 4th -> done=1, pass=1, vec_cnt=4, err_cnt=0. Handshakes spaced exactly 6 cycles apart when vec_valid is held high.
- Mismatch: same run with the expected value for 01 changed to 0 -> err_cnt=1, pass=0, vec_cnt=4. With the macro defined: vec_cnt=2, first_fail_idx=1, vectors 3 and 4 never accepted.
- Stall: drop vec_valid for 10 cycles after the 2nd vector -> vec_ready stays 1, dut_in holds 01, results identical to the clean run.
- Saturation: CNT_W=2, run 5 mismatching vectors -> err_cnt=3, vec_cnt=3, pass=0.
- Abort: assert rst_n=0 during SETTLE of the 2nd vector -> outputs reset immediately, no done; a subsequent clean run passes.
